// File: rtl/mult_unit.sv
// mult_unit: iterative shift-add multiplier for MULT/MULTU.
// Owns the architectural HI/LO registers and also serves MTHI/MTLO writes.
// One product bit is retired per clock. A multiply takes WIDTH RUN cycles
// plus one FINISH cycle, so the result lands on hi/lo 33 clocks after start.
module mult_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] result;

    // Datapath: operand magnitudes, partial-product add (carry kept) and final sign fix.
    // The magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude, so no special case is needed.
    always_comb begin
        abs_a  = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
        abs_b  = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
        addend = mplier_q[0] ? mcand_q : '0;
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        result = neg_q ? -acc_q : acc_q;
    end

    // Next-state logic for the sequencer, the iteration registers and HI/LO.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Moves to HI/LO land even if a multiply starts in the same
                // cycle; the product simply overwrites them later.
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    neg_d    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    mcand_d  = abs_a;
                    mplier_d = abs_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) state_d = FINISH;
            end
            FINISH: begin
                {hi_d, lo_d} = result;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State register; asynchronous reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed vectors for mult_unit with hand-computed products.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    int n_busy;
    bit done_while_busy;

    mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-22s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Advance one edge and sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a start edge; returns the number of samples with busy high.
    task automatic wait_done(output int nb);
        int edges;
        nb = 0;
        edges = 0;
        done_while_busy = 1'b0;
        while (busy === 1'b1 && edges < 40) begin
            nb++;
            if (done === 1'b1) done_while_busy = 1'b1;
            step();
            edges++;
        end
    endtask

    // Present operands and take the start edge (E0).
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
        step();
        start = 1'b0; op_a = 32'hA5A5_A5A5; op_b = 32'h5A5A_5A5A;
    endtask

    task automatic mult_case(input string tag, input logic sgn, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        launch(sgn, a, b);
        wait_done(n_busy);
        check({tag, "_busy_cycles"}, 32'(n_busy), 32'd33);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        step();
        check({tag, "_done_gone"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: MULTU all-ones squared
        mult_case("t1_multu_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        check("t1_no_done_while_busy", {31'd0, done_while_busy}, 32'd0);

        // 2: signed and unsigned on -3 x 7
        mult_case("t2_mult_m3x7", 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        mult_case("t2_multu_m3x7", 1'b0, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB);

        // 3: most negative operand
        mult_case("t3_min_x_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        mult_case("t3_min_x_1", 1'b1, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000);

        // 4: MTHI / MTLO in IDLE, ignored during RUN
        hi_we = 1'b1; wdata = 32'h1234_5678;
        step();
        hi_we = 1'b0;
        check("t4_mthi", hi, 32'h1234_5678);
        lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
        step();
        lo_we = 1'b0;
        check("t4_mtlo", lo, 32'h9ABC_DEF0);
        check("t4_hi_kept", hi, 32'h1234_5678);
        launch(1'b0, 32'd3, 32'd4);
        repeat (4) step();
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        step();
        check("t4_hi_run_hold", hi, 32'h1234_5678);
        check("t4_lo_run_hold", lo, 32'h9ABC_DEF0);
        wait_done(n_busy);
        check("t4_prod_hi", hi, 32'd0);
        check("t4_prod_lo", lo, 32'd12);
        step();

        // 4b: move coinciding with start lands, product later overwrites
        hi_we = 1'b1; wdata = 32'h0000_0055;
        launch(1'b0, 32'd9, 32'd9);
        hi_we = 1'b0;
        check("t4b_hi_moved", hi, 32'h0000_0055);
        wait_done(n_busy);
        check("t4b_busy_cycles", 32'(n_busy), 32'd33);
        check("t4b_hi_prod", hi, 32'd0);
        check("t4b_lo_prod", lo, 32'd81);
        step();

        // 5: start while busy ignored; back-to-back start in done cycle
        launch(1'b0, 32'd5, 32'd6);
        repeat (9) step();
        start = 1'b1; op_a = 32'd2; op_b = 32'd2;
        step();
        start = 1'b0;
        wait_done(n_busy);
        check("t5_busy_after_e10", 32'(n_busy), 32'd23);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_lo", lo, 32'd30);
        check("t5_hi", hi, 32'd0);
        launch(1'b0, 32'd2, 32'd2);
        check("t5_single_done", {31'd0, done}, 32'd0);
        check("t5_b2b_busy", {31'd0, busy}, 32'd1);
        check("t5_lo_held", lo, 32'd30);
        wait_done(n_busy);
        check("t5_b2b_cycles", 32'(n_busy), 32'd33);
        check("t5_b2b_done", {31'd0, done}, 32'd1);
        check("t5_b2b_lo", lo, 32'd4);
        step();

        // 6: asynchronous reset mid-operation
        launch(1'b0, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (14) step();
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_hi", hi, 32'd0);
        check("t6_rst_lo", lo, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        repeat (25) step();
        check("t6_rst_no_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        step();
        check("t6_idle_after_rst", {31'd0, busy}, 32'd0);
        mult_case("t6_after_rst", 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative shift-add multiplier for MIPS MULT/MULTU.
- Owns the architectural HI/LO registers; also serves MTHI/MTLO writes.
- Sits beside the EX-stage ALU and subtractor.
- The pipeline stalls on `busy`; MFHI/MFLO read `hi`/`lo` directly.
- One product bit per cycle keeps area small; result is a full 64-bit product.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits, product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin multiply; sampled only in IDLE.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- op_a  input  WIDTH  multiplicand (rs); sampled with start.
- op_b  input  WIDTH  multiplier (rt); sampled with start.
- hi_we  input  1  MTHI write enable; honoured only in IDLE.
- lo_we  input  1  MTLO write enable; honoured only in IDLE.
- wdata  input  WIDTH  MTHI/MTLO write data.
- busy  output  1  multiply in progress; pipeline must stall.
- done  output  1  one-cycle pulse when HI/LO hold a new product.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
  - All internal accumulators cleared.
- States: IDLE, RUN, FINISH.
- IDLE, start=1 at edge E0:
  - Latch neg = is_signed & (op_a[MSB] ^ op_b[MSB]).
  - Latch mcand = |op_a| and mplier = |op_b| when is_signed; raw values otherwise.
  - |-2^31| = 0x80000000, treated as unsigned.
  - Clear 2*WIDTH accumulator, counter=0; go to RUN.
  - busy=1 from the cycle after E0.
- RUN, each edge:
  - If mplier[0]=1, add mcand into the upper WIDTH+1 bits of the accumulator (carry retained).
  - Shift accumulator and mplier right by one; counter increments.
  - After WIDTH iterations (edges E1..E32), go to FINISH.
- FINISH, edge E33:
  - {hi,lo} = neg ? two's-complement negation of the 64-bit accumulator : accumulator.
  - done=1 for exactly the cycle after E33; busy=0 in that same cycle.
  - Return to IDLE.
- Latency: result visible on hi/lo 33 clocks after start is sampled.
- Back-to-back: a new start is accepted in the done cycle.
- start while busy: ignored; the operation in flight is not disturbed.
- hi_we/lo_we:
  - In IDLE, the write takes effect at the next edge.
  - If either coincides with start in IDLE, the write takes effect and the multiply still starts; the product later overwrites both registers.
  - Ignored while busy.
- Operands op_a/op_b may change freely after the start edge.
- hi/lo hold their value throughout RUN; there is no partial-result visibility.
- Reset asserted mid-operation: the operation is aborted, with reset values as above and no done pulse.
- Zero operands still take the full 33 cycles; there is no early termination.

Test Plan:
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at E0 -> busy high for 33 cycles, done pulse after E33; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT -3 (0xFFFFFFFD) × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also MULTU on the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
3. MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000. MULT 0x80000000 × 1 -> hi=0xFFFFFFFF, lo=0x80000000.
4. MTHI 0x12345678 then MTLO 0x9ABCDEF0 in IDLE -> hi/lo update on the next edge. Repeat with hi_we pulsed during RUN -> hi unchanged.
5. start 5×6, then start=1 again with 2×2 at E10 -> ignored; after E33 lo=30, hi=0, single done pulse. A start in the done cycle is accepted, and the second product (lo=4) arrives 33 clocks later.
6. start 0xFFFF×0xFFFF, rst_n low at E15 -> hi=lo=0, busy=0 immediately, no done. After release, the next multiply behaves normally.
